// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation modes, flag bit positions
// and the controller state encoding.
package alu_pkg;

    typedef enum logic [4:0] {
        MODE_ADD   = 5'h00,
        MODE_SUB   = 5'h01,
        MODE_PASS1 = 5'h02,
        MODE_PASS2 = 5'h03,
        MODE_AND   = 5'h04,
        MODE_OR    = 5'h05,
        MODE_XOR   = 5'h06,
        MODE_RSUB  = 5'h07,
        MODE_INC   = 5'h08,
        MODE_DEC   = 5'h09,
        MODE_ROL   = 5'h0A,
        MODE_ROR   = 5'h0B,
        MODE_SHL   = 5'h0C,
        MODE_SHR   = 5'h0D,
        MODE_ASR   = 5'h0E,
        MODE_NEG   = 5'h0F,
        MODE_ADC   = 5'h10,
        MODE_SBB   = 5'h11,
        MODE_MULU  = 5'h12,
        MODE_DIVU  = 5'h13
    } alu_mode_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } alu_state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: MSB-first shift-add multiply and restoring
// divide, one step per enabled cycle; exposes the post-step accumulator.
module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic             step_i,
    output logic             last_o,
    output logic             is_div_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   shf_q;
    logic [WIDTH-1:0]   opb_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q;
    logic [WIDTH:0]     rem_sh, rem_sub;

    // NOTE: every variable is given a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_d   = acc_q;
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], shf_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, opb_q};
        if (div_q) begin
            // hi half holds the partial remainder, lo half collects quotient bits
            if (!rem_sub[WIDTH]) begin
                acc_d = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = (acc_q << 1) + (shf_q[WIDTH-1] ? {{WIDTH{1'b0}}, opb_q} : '0);
        end
    end

    assign lo_o     = acc_d[WIDTH-1:0];
    assign hi_o     = acc_d[2*WIDTH-1:WIDTH];
    assign last_o   = (cnt_q == '0);
    assign is_div_o = div_q;

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: these are plain flops, not a RAM, so they are all reset; the counter must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            shf_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= '0;
            shf_q <= op1_i;
            opb_q <= op2_i;
            cnt_q <= CW'(WIDTH - 1);
            div_q <= is_div_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            shf_q <= shf_q << 1;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake: single-cycle modes complete at
// acceptance, MULU/DIVU run WIDTH steps on the shared iterative datapath.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       mode,
    input  logic [3:0]       cflags,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [3:0]         flags_q, flags_d;

    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   add_a, add_b;
    logic               add_cin, is_arith;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] rot;
    logic [WIDTH-1:0]   sc_res, sc_hi;
    logic [3:0]         sc_flags;

    logic               it_load, it_step, it_last, it_div, is_multi;
    logic [WIDTH-1:0]   it_lo, it_hi;

    // Single-cycle unit; every add/sub variant is folded onto a + b + cin.
    always_comb begin
        sh       = operand1[SHW-1:0];
        add_a    = operand1;
        add_b    = operand2;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        rot      = '0;
        sc_res   = operand2;
        sc_hi    = '0;
        case (mode)
            MODE_ADD:  is_arith = 1'b1;
            MODE_SUB:  begin add_b = ~operand2; add_cin = 1'b1; is_arith = 1'b1; end
            MODE_RSUB: begin add_a = operand2; add_b = ~operand1; add_cin = 1'b1; is_arith = 1'b1; end
            MODE_INC:  begin add_a = operand2; add_b = '0; add_cin = 1'b1; is_arith = 1'b1; end
            MODE_DEC:  begin add_a = operand2; add_b = '1; is_arith = 1'b1; end
            MODE_NEG:  begin add_a = '0; add_b = ~operand2; add_cin = 1'b1; is_arith = 1'b1; end
            MODE_ADC:  begin add_cin = cflags[FLAG_C]; is_arith = 1'b1; end
            MODE_SBB:  begin add_b = ~operand2; add_cin = cflags[FLAG_C]; is_arith = 1'b1; end
            default:   ;
        endcase
        add_sum = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);

        case (mode)
            MODE_PASS1: sc_res = operand1;
            MODE_AND:   sc_res = operand1 & operand2;
            MODE_OR:    sc_res = operand1 | operand2;
            MODE_XOR:   sc_res = operand1 ^ operand2;
            MODE_ROL:   begin rot = {operand2, operand2} << sh; sc_res = rot[2*WIDTH-1:WIDTH]; end
            MODE_ROR:   begin rot = {operand2, operand2} >> sh; sc_res = rot[WIDTH-1:0]; end
            MODE_SHL:   sc_res = operand2 << sh;
            MODE_SHR:   sc_res = operand2 >> sh;
            MODE_ASR:   sc_res = $signed(operand2) >>> sh;
            MODE_DIVU:  begin sc_res = '1; sc_hi = operand1; end
            default:    if (is_arith) sc_res = add_sum[WIDTH-1:0];
        endcase

        sc_flags[FLAG_Z] = (sc_res == '0);
        sc_flags[FLAG_S] = sc_res[WIDTH-1];
        sc_flags[FLAG_C] = is_arith ? add_sum[WIDTH] : cflags[FLAG_C];
        sc_flags[FLAG_O] = is_arith && (add_a[WIDTH-1] == add_b[WIDTH-1])
                                    && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
        if (mode == MODE_DIVU) begin
            // only reached for a zero divisor; real divides go iterative
            sc_flags[FLAG_S] = 1'b0;
            sc_flags[FLAG_C] = |operand1;
            sc_flags[FLAG_O] = 1'b1;
        end
    end

    assign is_multi = (mode == MODE_MULU) || ((mode == MODE_DIVU) && (operand2 != '0));

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        it_load     = 1'b0;
        it_step     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && is_multi) begin
                    it_load = 1'b1;
                    state_d = ST_ITER;
                end else if (start) begin
                    done_d      = 1'b1;
                    result_d    = sc_res;
                    result_hi_d = sc_hi;
                    flags_d     = sc_flags;
                end
            end
            ST_ITER: begin
                it_step = 1'b1;
                if (it_last) begin
                    state_d          = ST_IDLE;
                    done_d           = 1'b1;
                    result_d         = it_lo;
                    result_hi_d      = it_hi;
                    flags_d[FLAG_Z]  = it_div ? (it_lo == '0) : ({it_hi, it_lo} == '0);
                    flags_d[FLAG_C]  = (it_hi != '0);
                    flags_d[FLAG_S]  = it_div ? 1'b0 : it_lo[WIDTH-1];
                    flags_d[FLAG_O]  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (it_load),
        .is_div_i (mode == MODE_DIVU),
        .op1_i    (operand1),
        .op2_i    (operand2),
        .step_i   (it_step),
        .last_o   (it_last),
        .is_div_o (it_div),
        .lo_o     (it_lo),
        .hi_o     (it_hi)
    );

    assign busy      = (state_q == ST_ITER);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: WIDTH=8 instance compared every cycle
// against a timeline model, plus directed and random WIDTH=16 operations.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [4:0]  mode = '0;
    logic [3:0]  cflags = '0;
    logic [15:0] op1 = '0, op2 = '0;

    logic        busy8, done8, busy16, done16;
    logic [7:0]  res8, hi8;
    logic [15:0] res16, hi16;
    logic [3:0]  fl8, fl16;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode), .cflags(cflags),
        .operand1(op1[7:0]), .operand2(op2[7:0]), .busy(busy8), .done(done8),
        .result(res8), .result_hi(hi8), .flags(fl8)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode), .cflags(cflags),
        .operand1(op1), .operand2(op2), .busy(busy16), .done(done16),
        .result(res16), .result_hi(hi16), .flags(fl16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers; flags returned as {Z,C,S,O}.
    function automatic void model(input int w, input logic [4:0] m, input logic [3:0] cf,
                                  input longint a, input longint b,
                                  output longint r, output longint rh, output logic [3:0] fl);
        longint mask, half, full, sa, sb, so, ci, p;
        int n;
        logic c, o, arith;
        mask  = (longint'(1) << w) - 1;
        half  = longint'(1) << (w - 1);
        sa    = (a >= half) ? a - (mask + 1) : a;
        sb    = (b >= half) ? b - (mask + 1) : b;
        ci    = longint'(cf[2]);
        n     = int'(a % longint'(w));
        c     = cf[2];
        o     = 1'b0;
        arith = 1'b1;
        so    = 0;
        rh    = 0;
        r     = b;
        if (m == 5'h12) begin
            p  = a * b;
            r  = p & mask;
            rh = p >> w;
            fl = {p == 0, rh != 0, ((r >> (w - 1)) & 1) != 0, 1'b0};
            return;
        end
        if (m == 5'h13) begin
            if (b == 0) begin
                r = mask; rh = a; fl = {1'b0, a != 0, 1'b0, 1'b1};
            end else begin
                r = a / b; rh = a % b; fl = {r == 0, rh != 0, 1'b0, 1'b0};
            end
            return;
        end
        case (m)
            5'h00: begin full = a + b; r = full; c = full > mask; so = sa + sb; end
            5'h01: begin r = a - b; c = a >= b; so = sa - sb; end
            5'h02: begin r = a; arith = 0; end
            5'h04: begin r = a & b; arith = 0; end
            5'h05: begin r = a | b; arith = 0; end
            5'h06: begin r = a ^ b; arith = 0; end
            5'h07: begin r = b - a; c = b >= a; so = sb - sa; end
            5'h08: begin r = b + 1; c = b == mask; so = sb + 1; end
            5'h09: begin r = b - 1; c = b != 0; so = sb - 1; end
            5'h0A: begin r = (b << n) | (b >> (w - n)); arith = 0; end
            5'h0B: begin r = (b >> n) | (b << (w - n)); arith = 0; end
            5'h0C: begin r = b << n; arith = 0; end
            5'h0D: begin r = b >> n; arith = 0; end
            5'h0E: begin r = sb >>> n; arith = 0; end
            5'h0F: begin r = -b; c = b == 0; so = -sb; end
            5'h10: begin full = a + b + ci; r = full; c = full > mask; so = sa + sb + ci; end
            5'h11: begin r = a - b - (1 - ci); c = a >= b + (1 - ci); so = sa - sb - (1 - ci); end
            default: begin r = b; arith = 0; end
        endcase
        r = r & mask;
        if (arith) o = (so < -half) || (so >= half);
        fl = {r == 0, c, ((r >> (w - 1)) & 1) != 0, o};
    endfunction

    function automatic int model_lat(input int w, input logic [4:0] m, input longint b);
        return (m == 5'h12 || (m == 5'h13 && b != 0)) ? w + 1 : 1;
    endfunction

    // Timeline of the expected WIDTH=8 outputs, advanced once per rising edge.
    longint     e_res = 0, e_hi = 0, p_res = 0, p_hi = 0, mr, mh;
    logic [3:0] e_fl = '0, p_fl = '0, mf;
    logic       e_busy = 1'b0, e_done = 1'b0;
    int         e_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_res = 0; e_hi = 0; e_fl = '0; e_busy = 1'b0; e_done = 1'b0; e_cnt = 0;
        end else begin
            e_done = 1'b0;
            if (e_cnt > 0) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    e_done = 1'b1; e_busy = 1'b0;
                    e_res = p_res; e_hi = p_hi; e_fl = p_fl;
                end
            end else if (start8) begin
                model(8, mode, cflags, longint'(op1[7:0]), longint'(op2[7:0]), mr, mh, mf);
                if (model_lat(8, mode, longint'(op2[7:0])) == 1) begin
                    e_done = 1'b1; e_res = mr; e_hi = mh; e_fl = mf;
                end else begin
                    p_res = mr; p_hi = mh; p_fl = mf; e_cnt = 8; e_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("w8 busy", busy8, e_busy);
            check("w8 done", done8, e_done);
            check("w8 result", res8, e_res);
            check("w8 result_hi", hi8, e_hi);
            check("w8 flags", fl8, e_fl);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit sel16, input logic [4:0] m, input logic [3:0] cf,
                         input logic [15:0] a, input logic [15:0] b);
        mode = m; cflags = cf; op1 = a; op2 = b;
        if (sel16) start16 = 1'b1; else start8 = 1'b1;
        tick();
        start8 = 1'b0; start16 = 1'b0;
        mode = 5'($urandom); cflags = 4'($urandom); op1 = 16'($urandom); op2 = 16'($urandom);
    endtask

    // Returns edges from acceptance to done, acceptance edge counted as 1.
    task automatic wait_done(input bit sel16, input bit poke, output int lat);
        lat = 1;
        while (!(sel16 ? done16 : done8) && lat < 40) begin
            if (poke && lat == 3) begin
                mode = MODE_ADD;
                if (sel16) start16 = 1'b1; else start8 = 1'b1;
            end
            tick();
            start8 = 1'b0; start16 = 1'b0;
            lat++;
        end
    endtask

    task automatic run(input bit sel16, input string name, input logic [4:0] m,
                       input logic [3:0] cf, input logic [15:0] a, input logic [15:0] b,
                       input longint xr, input longint xh, input logic [3:0] xf,
                       input int xl, input bit poke);
        int lat;
        issue(sel16, m, cf, a, b);
        wait_done(sel16, poke, lat);
        check({name, " latency"}, lat, xl);
        check({name, " result"}, sel16 ? res16 : {8'h00, res8}, xr);
        check({name, " result_hi"}, sel16 ? hi16 : {8'h00, hi8}, xh);
        check({name, " flags"}, sel16 ? fl16 : fl8, xf);
    endtask

    function automatic logic [15:0] pick_operand(input int w);
        logic [15:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'hFFFF;
            2: v = 16'h7FFF;
            3: v = 16'h8000;
            4: v = 16'h0001;
            default: v = 16'($urandom);
        endcase
        if (w == 8) v = {8'h00, v[15] ^ v[7] ? v[15:8] : v[7:0]};
        return v;
    endfunction

    initial begin
        int lat;
        logic [4:0] m;
        logic [3:0] cf;
        logic [15:0] a, b;

        model(8, MODE_ADD, 4'b0000, 64'h7F, 64'h01, mr, mh, mf);
        check("model add 7f+01", {mf, 8'(mr)}, {4'b0011, 8'h80});
        model(16, MODE_MULU, 4'b0000, 64'hFFFF, 64'h2, mr, mh, mf);
        check("model mulu16", {mh, mr}, {64'h1, 64'hFFFE});

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset busy", busy8, 1'b0);
        check("reset done", done8, 1'b0);
        check("reset result", {res8, hi8, fl8}, 20'h0);

        run(0, "add 7f+01", MODE_ADD, 4'b0000, 16'h7F, 16'h01, 64'h80, 0, 4'b0011, 1, 0);
        run(0, "add ff+01", MODE_ADD, 4'b0000, 16'hFF, 16'h01, 64'h00, 0, 4'b1100, 1, 0);
        run(0, "adc ff+00", MODE_ADC, 4'b0100, 16'hFF, 16'h00, 64'h00, 0, 4'b1100, 1, 0);
        run(0, "sub 05-07", MODE_SUB, 4'b0000, 16'h05, 16'h07, 64'hFE, 0, 4'b0010, 1, 0);
        run(0, "and keep c", MODE_AND, 4'b0101, 16'hF3, 16'h3F, 64'h33, 0, 4'b0100, 1, 0);
        run(0, "mulu ff*ff", MODE_MULU, 4'b0000, 16'hFF, 16'hFF, 64'h01, 64'hFE, 4'b0100, 9, 1);
        run(0, "divu 200/7", MODE_DIVU, 4'b0000, 16'd200, 16'd7, 64'd28, 64'd4, 4'b0100, 9, 0);
        run(0, "divu 13/0", MODE_DIVU, 4'b0000, 16'd13, 16'd0, 64'hFF, 64'd13, 4'b0101, 1, 0);
        run(0, "rol 81 by 1", MODE_ROL, 4'b0000, 16'h01, 16'h81, 64'h03, 0, 4'b0000, 1, 0);
        run(0, "asr 80 by 3", MODE_ASR, 4'b0000, 16'h03, 16'h80, 64'hF0, 0, 4'b0010, 1, 0);
        run(0, "neg 80", MODE_NEG, 4'b0000, 16'h00, 16'h80, 64'h80, 0, 4'b0011, 1, 0);

        issue(0, MODE_MULU, 4'b0000, 16'h12, 16'h34);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", busy8, 1'b0);
        check("abort done", done8, 1'b0);
        check("abort outputs", {res8, hi8, fl8}, 20'h0);
        tick();
        rst_n = 1'b1;
        run(0, "add 1+1 after reset", MODE_ADD, 4'b0000, 16'h01, 16'h01, 64'h02, 0, 4'b0000, 1, 0);

        for (int i = 0; i < 400; i++) begin
            m  = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 19)) : 5'($urandom_range(20, 31));
            cf = 4'($urandom);
            a  = pick_operand(8);
            b  = pick_operand(8);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) tick();
            issue(0, m, cf, a, b);
            wait_done(0, $urandom_range(0, 3) == 0, lat);
            check("w8 random latency", lat, model_lat(8, m, longint'(b[7:0])));
        end

        run(1, "mulu16 ffff*2", MODE_MULU, 4'b0000, 16'hFFFF, 16'h0002, 64'hFFFE, 64'h1, 4'b0110, 17, 1);
        for (int i = 0; i < 60; i++) begin
            m  = 5'($urandom_range(0, 21));
            cf = 4'($urandom);
            a  = pick_operand(16);
            b  = pick_operand(16);
            model(16, m, cf, longint'(a), longint'(b), mr, mh, mf);
            run(1, "w16 random", m, cf, a, b, mr, mh, mf, model_lat(16, m, longint'(b)), 0);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
